// File: rtl/timer_seq_ctrl.sv
// Timer sequencing controller: IDLE/LOAD/RUN FSM that loads, enables and reloads an external 8-bit timer.
// Optional terminal-event counter output evt_cnt enabled by macro TIMER_SEQ_EVT_CNT_EN.
module timer_seq_ctrl #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [7:0]         init_val,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               irq_clr,
    input  logic               over,
    input  logic               under,
    output logic               tmr_en,
    output logic               tmr_updown,
    output logic               tmr_init_cnt,
    output logic [7:0]         tmr_data_in,
    output logic               busy,
    output logic               irq
`ifdef TIMER_SEQ_EVT_CNT_EN
    ,
    output logic [7:0]         evt_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [7:0]         init_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_nxt;
    logic               term;

    // tmr_en is registered, so it is computed from the count the next cycle will hold;
    // the >= guard keeps the counter bounded if prescale shrinks mid-run.
    always_comb begin
        presc_nxt = (presc_cnt >= prescale) ? '0 : presc_cnt + PRESC_W'(1);
        term      = tmr_updown ? over : under;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mode_q       <= '0;
            init_q       <= '0;
            presc_cnt    <= '0;
            tmr_en       <= 1'b0;
            tmr_updown   <= 1'b1;
            tmr_init_cnt <= 1'b0;
            tmr_data_in  <= '0;
            irq          <= 1'b0;
`ifdef TIMER_SEQ_EVT_CNT_EN
            evt_cnt      <= '0;
`endif
        end else begin
            tmr_en       <= 1'b0;
            tmr_init_cnt <= 1'b0;
            if (irq_clr)
                irq <= 1'b0;

            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state        <= LOAD;
                            mode_q       <= mode;
                            init_q       <= init_val;
                            tmr_init_cnt <= 1'b1;
                            tmr_data_in  <= init_val;
                            tmr_updown   <= (mode != 2'b01);
`ifdef TIMER_SEQ_EVT_CNT_EN
                            evt_cnt      <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        state     <= RUN;
                        presc_cnt <= '0;
                        tmr_en    <= (prescale == '0);
                    end
                    RUN: begin
                        if (term) begin
                            irq <= 1'b1;
`ifdef TIMER_SEQ_EVT_CNT_EN
                            if (evt_cnt != 8'hFF)
                                evt_cnt <= evt_cnt + 8'd1;
`endif
                            if (mode_q[1]) begin
                                state        <= LOAD;
                                tmr_init_cnt <= 1'b1;
                                tmr_data_in  <= init_q;
                                if (mode_q[0])
                                    tmr_updown <= ~tmr_updown;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            presc_cnt <= presc_nxt;
                            tmr_en    <= (presc_nxt == prescale);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed self-checking bench for timer_seq_ctrl; evt_cnt checks compile in with TIMER_SEQ_EVT_CNT_EN.
`timescale 1ns/1ps
module tb_timer_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, irq_clr, over, under;
    logic [1:0] mode;
    logic [7:0] init_val;
    logic [3:0] prescale;
    logic       tmr_en, tmr_updown, tmr_init_cnt, busy, irq;
    logic [7:0] tmr_data_in;
`ifdef TIMER_SEQ_EVT_CNT_EN
    logic [7:0] evt_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] en_pat;

    always #5 clk = ~clk;

    timer_seq_ctrl #(.PRESC_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .init_val(init_val), .prescale(prescale), .irq_clr(irq_clr),
        .over(over), .under(under), .tmr_en(tmr_en), .tmr_updown(tmr_updown),
        .tmr_init_cnt(tmr_init_cnt), .tmr_data_in(tmr_data_in),
        .busy(busy), .irq(irq)
`ifdef TIMER_SEQ_EVT_CNT_EN
        , .evt_cnt(evt_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; outputs are then stable for sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; irq_clr = 0; over = 0; under = 0;
        mode = 2'b00; init_val = 8'd0; prescale = 4'd0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_en", tmr_en, 0);
        check("rst_init", tmr_init_cnt, 0);
        check("rst_ud", tmr_updown, 1);
        check("rst_data", tmr_data_in, 0);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        step();

        // one-shot up, prescale 0
        mode = 2'b00; init_val = 8'd250; prescale = 4'd0; start = 1;
        step();
        start = 0;
        check("m0_load_init", tmr_init_cnt, 1);
        check("m0_load_data", tmr_data_in, 250);
        check("m0_load_en", tmr_en, 0);
        check("m0_load_ud", tmr_updown, 1);
        check("m0_load_busy", busy, 1);
        step();
        check("m0_run_en1", tmr_en, 1);
        check("m0_run_init", tmr_init_cnt, 0);
        start = 1; init_val = 8'd5;
        step();
        start = 0;
        check("m0_start_ignored", tmr_init_cnt, 0);
        check("m0_run_en2", tmr_en, 1);
        over = 1;
        step();
        over = 0;
        check("m0_done_busy", busy, 0);
        check("m0_done_irq", irq, 1);
        check("m0_done_en", tmr_en, 0);
        check("m0_idle_data", tmr_data_in, 250);
        irq_clr = 1;
        step();
        irq_clr = 0;
        check("irq_cleared", irq, 0);

        // one-shot down, prescale 3, stray over ignored
        mode = 2'b01; init_val = 8'd50; prescale = 4'd3; start = 1;
        step();
        start = 0;
        check("m1_load_ud", tmr_updown, 0);
        check("m1_load_data", tmr_data_in, 50);
        step();
        en_pat = '0;
        for (int k = 0; k < 8; k++) begin
            en_pat[k] = tmr_en;
            over = (k == 5);
            step();
        end
        over = 0;
        check("m1_en_pattern", en_pat, 8'h88);
        check("m1_over_ignored", busy, 1);
        check("m1_irq_quiet", irq, 0);
        under = 1;
        step();
        under = 0;
        check("m1_done_busy", busy, 0);
        check("m1_done_irq", irq, 1);
        irq_clr = 1;
        step();
        irq_clr = 0;

        // ping-pong
        mode = 2'b11; init_val = 8'd100; prescale = 4'd0; start = 1;
        step();
        start = 0;
        check("m3_load1_ud", tmr_updown, 1);
        step();
        over = 1;
        step();
        over = 0;
        check("m3_load2_init", tmr_init_cnt, 1);
        check("m3_load2_ud", tmr_updown, 0);
        check("m3_load2_data", tmr_data_in, 100);
        check("m3_irq_set", irq, 1);
        step();
        under = 1; irq_clr = 1;
        step();
        under = 0; irq_clr = 0;
        check("m3_load3_init", tmr_init_cnt, 1);
        check("m3_load3_ud", tmr_updown, 1);
        check("m3_set_wins", irq, 1);
        step();
        step();
        check("m3_irq_sticky", irq, 1);
        irq_clr = 1;
        step();
        irq_clr = 0;
        check("m3_irq_clr", irq, 0);
        stop = 1;
        step();
        stop = 0;
        check("m3_stop_busy", busy, 0);

        // auto-reload, then stop colliding with over
        mode = 2'b10; init_val = 8'd7; prescale = 4'd1; start = 1;
        step();
        start = 0;
        step();
        check("m2_run_en0", tmr_en, 0);
        step();
        check("m2_run_en1", tmr_en, 1);
        over = 1;
        step();
        over = 0;
        check("m2_reload_init", tmr_init_cnt, 1);
        check("m2_reload_ud", tmr_updown, 1);
        irq_clr = 1;
        step();
        irq_clr = 0;
        step();
        stop = 1; over = 1;
        step();
        stop = 0; over = 0;
        check("m2_stop_busy", busy, 0);
        check("m2_stop_irq", irq, 0);
        check("m2_stop_noload", tmr_init_cnt, 0);
        step();
        check("m2_idle_data", tmr_data_in, 7);
        check("m2_idle_ud", tmr_updown, 1);

        // asynchronous reset mid-run
        mode = 2'b00; init_val = 8'd9; prescale = 4'd0; start = 1;
        step();
        start = 0;
        step();
        step();
        check("ar_pre_en", tmr_en, 1);
        #2 rst = 1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_en", tmr_en, 0);
        check("ar_data", tmr_data_in, 0);
        check("ar_ud", tmr_updown, 1);
        check("ar_irq", irq, 0);
        rst = 0;
        step();
        step();
        check("ar_wait_start", busy, 0);
        init_val = 8'd33; start = 1;
        step();
        start = 0;
        check("ar_load_init", tmr_init_cnt, 1);
        check("ar_load_data", tmr_data_in, 33);
        stop = 1;
        step();
        stop = 0;

`ifdef TIMER_SEQ_EVT_CNT_EN
        mode = 2'b10; init_val = 8'd0; prescale = 4'd0; start = 1;
        step();
        start = 0;
        check("ec_start_zero", evt_cnt, 0);
        step();
        for (int i = 0; i < 300; i++) begin
            over = 1;
            step();
            over = 0;
            step();
        end
        check("ec_saturate", evt_cnt, 255);
        stop = 1;
        step();
        stop = 0;
        start = 1;
        step();
        start = 0;
        check("ec_clear", evt_cnt, 0);
        stop = 1;
        step();
        stop = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter PRESC_W, default 4, prescaler field width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a timing run.
REQ-005 SHALL have port stop  input  1  single-cycle request to abort the run.
REQ-006 SHALL have port mode  input  2  run mode: 00 one-shot up, 01 one-shot down, 10 auto-reload up, 11 ping-pong.
REQ-007 SHALL have port init_val  input  8  value loaded into the timer on every load.
REQ-008 SHALL have port prescale  input  PRESC_W  timer enable divider; the timer advances once every prescale+1 cycles.
REQ-009 SHALL have port irq_clr  input  1  clears irq.
REQ-010 SHALL have ports over and under  input  1 each  timer overflow/underflow flags.
REQ-011 SHALL have ports tmr_en, tmr_updown, tmr_init_cnt  output  1 each, plus tmr_data_in  output  8; all drive the timer.
REQ-012 SHALL have ports busy  output  1 (state not IDLE) and irq  output  1 (sticky event flag).

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, with registered outputs.
REQ-014 In IDLE, start=1 SHALL latch mode and init_val, and move to LOAD on the next edge; start in LOAD or RUN SHALL be ignored.
REQ-015 LOAD SHALL last exactly one cycle, with tmr_init_cnt=1, tmr_data_in=latched init_val and tmr_en=0, then move to RUN.
REQ-016 tmr_updown SHALL be 1 for modes 00 and 10, and 0 for mode 01, from the LOAD cycle onward; ping-pong starts at 1.
REQ-017 On entering RUN the prescaler count SHALL be 0.
REQ-018 In RUN, tmr_en SHALL be 1 for one cycle when the prescaler count equals prescale, after which the count returns to 0; prescale=0 gives tmr_en=1 on every RUN cycle.
REQ-019 The terminal event SHALL be over when tmr_updown=1 and under when tmr_updown=0; a flag in the other direction SHALL be ignored.
REQ-020 On a terminal event in modes 00 or 01, the block SHALL go to IDLE.
REQ-021 On a terminal event in mode 10, the block SHALL go to LOAD with the same direction.
REQ-022 On a terminal event in mode 11, the block SHALL go to LOAD and invert tmr_updown.
REQ-023 Every terminal event SHALL set irq on the following edge, and irq SHALL remain set until irq_clr.
REQ-024 If a set and irq_clr occur in the same cycle, the set SHALL win.
REQ-025 stop=1 in any state SHALL force IDLE on the next edge, and takes precedence over start and over any terminal event in the same cycle; no irq is set in that case.
REQ-026 In IDLE, tmr_en=0, tmr_init_cnt=0, and tmr_data_in and tmr_updown SHALL hold their last values.
REQ-027 mode, init_val and prescale changes during a run SHALL NOT take effect until the next start, except prescale, which is sampled live.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, prescaler count 0, tmr_en=0, tmr_init_cnt=0, tmr_updown=1, tmr_data_in=0, busy=0, irq=0, independent of clk.
REQ-029 rst asserted mid-run SHALL abort without setting irq, and the block SHALL await a fresh start after release.

Configuration
REQ-030 With macro TIMER_SEQ_EVT_CNT_EN defined, the block SHALL add output evt_cnt (8 bits), which increments on each terminal event, saturates at 255, and is cleared by rst or by start accepted in IDLE.
REQ-031 Without TIMER_SEQ_EVT_CNT_EN, port evt_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Mode 00, init_val=250, prescale=0, start -> LOAD one cycle with tmr_data_in=250; then tmr_en=1 every cycle; over -> IDLE and irq=1 next edge; busy=0.
REQ-033 Mode 01, prescale=3 -> tmr_en high exactly 1 of every 4 RUN cycles; under -> IDLE; an over pulse injected during the run is ignored.
REQ-034 Mode 11, init_val=100 -> over, then a LOAD with tmr_updown=0 and data 100; under, then a LOAD with tmr_updown=1; irq stays 1 until irq_clr; irq_clr coincident with the event leaves irq=1.
REQ-035 Mode 10 running; stop and over in the same cycle -> IDLE next edge, irq remains 0, no LOAD.
REQ-036 rst pulsed between clock edges mid-RUN -> all outputs reach reset values before the next edge; start after release -> normal LOAD.
REQ-037 With TIMER_SEQ_EVT_CNT_EN, mode 10 with 300 overflows -> evt_cnt=255; a new start -> evt_cnt=0.
